rv32i_pipe_ctrl: RTL and testbench
==================================

// Module: rv32i_pipe_ctrl
// PURPOSE
// Hazard/sequencing controller for the 5-stage rv32i pipeline (IF, ID, EX, MEM, WB).
// Watches the IR of each pipeline stage and drives the following controls:
//   - PC and IF/ID enables
//   - IF/ID flush and ID/EX bubble insertion
//   - EX hold while a multi-cycle MUL is in EX
//   - EX operand forwarding selects
// Also keeps saturating stall and flush event counters for bring-up and debug.
// PARAMETERS
// XLEN      32  instruction/data width
// MUL_LAT   4   number of cycles a MUL occupies EX (1 = single-cycle, no hold)
// FLUSH_CYC 3   number of cycles flush/bubble stays asserted after a taken branch
// CNT_W     16  width of the event counters
// PORTS
// clk          in  1      pipeline clock
// RN           in  1      reset; synchronous, active-high
// id_ir        in  XLEN   IF/ID instruction
// id_valid     in  1      IF/ID slot holds a real instruction
// ex_ir        in  XLEN   ID/EX instruction
// ex_valid     in  1      ID/EX slot valid
// mem_ir       in  XLEN   EX/MEM instruction
// mem_valid    in  1      EX/MEM slot valid
// wb_ir        in  XLEN   MEM/WB instruction
// wb_valid     in  1      MEM/WB slot valid
// br_taken     in  1      EX-stage branch resolved taken; qualified by ex_valid
// pc_en        out 1      NPC may update
// if_id_en     out 1      IF/ID register may load
// if_id_flush  out 1      IF/ID loads a bubble (valid=0)
// id_ex_bubble out 1      ID/EX loads a bubble instead of the ID instruction
// ex_hold      out 1      EX keeps its inputs and EX/MEM does not advance
// fwd_a        out 2      source for EX operand A: 0=regfile, 1=EX/MEM ALUOUT, 2=MEM/WB result
// fwd_b        out 2      source for EX operand B; same encoding as fwd_a
// stall_cnt    out CNT_W  cycles with pc_en=0 (saturating)
// flush_cnt    out CNT_W  cycles with if_id_flush=1 (saturating)
// BEHAVIOUR
// Instruction decode:
//   - opcode = ir[6:0]: AR=0, M=1, BR=2, SH=3.
//   - funct3 = ir[14:12]; rd = ir[11:7]; rs1 = ir[19:15]; rs2 = ir[24:20].
//   - writes_rd: (AR or SH, or M with funct3 LW=0) and rd != 0.
//   - reads rs1: AR, SH, M.
//   - reads rs2: AR with ir[31:25]==1, and SH.
//   - SW (M, funct3=1) also reads register ir[11:7] as store data.
//   - BR reads no registers, because it compares field indices.
//   - is_mul: AR, ir[31:25]==1, funct3==6.
// FSM states: RUN, MUL_WAIT, FLUSH. There is one down-counter cnt, wide enough for max(MUL_LAT, FLUSH_CYC).
// RUN (priority top-down, all outputs Mealy):
//   - ex_valid & br_taken:
//       outputs if_id_flush=1, id_ex_bubble=1, pc_en=1.
//       If FLUSH_CYC>1: cnt<=FLUSH_CYC-2, next state FLUSH.
//   - ex_valid & is_mul(ex_ir) & MUL_LAT>1:
//       outputs ex_hold=1, pc_en=0, if_id_en=0.
//       cnt<=MUL_LAT-2, next state MUL_WAIT.
//   - Load-use hazard: ex is a valid LW and its rd matches a register read by a valid id_ir.
//       outputs pc_en=0, if_id_en=0, id_ex_bubble=1 for exactly this cycle.
//       Stay in RUN; the hazard clears naturally once the LW moves to MEM.
//   - Otherwise: pc_en=1, if_id_en=1, all other controls 0.
// MUL_WAIT: ex_hold=1, pc_en=0, if_id_en=0. On cnt==0 go to RUN, else cnt decrements.
// FLUSH: if_id_flush=1, id_ex_bubble=1, pc_en=1. On cnt==0 go to RUN, else cnt decrements.
// Forwarding (combinational, all states), evaluated per ex_ir source register r:
//   - fwd=1 if mem_valid & writes_rd(mem_ir) & !LW(mem_ir) & rd(mem_ir)==r.
//   - else fwd=2 if wb_valid & writes_rd(wb_ir) & rd(wb_ir)==r.
//   - else fwd=0.
//   - r==0 always gives fwd=0.
//   - A LW in EX/MEM is never forwarded; the load-use stall covers that case.
// Priorities and boundary cases:
//   - A branch and a load-use hazard in the same cycle: the branch wins; no stall cycle, no stall count.
//   - A branch cannot reach EX while in MUL_WAIT (EX is held), so a branch in that state is ignored.
//   - Invalid stage slots never cause hazards or forwarding.
// Counters:
//   - stall_cnt increments on every cycle with pc_en=0.
//   - flush_cnt increments on every cycle with if_id_flush=1.
//   - Both hold at all-ones.
// Reset (RN=1 at a clk edge, in any state, including mid-MUL or mid-FLUSH):
//   - next state RUN, cnt=0, stall_cnt=0, flush_cnt=0.
//   - While RN=1 the outputs are forced to: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1,
//     ex_hold=0, fwd_a=fwd_b=0.
//   - Reset cycles are not counted.
// STRUCTURE
// Package rv32i_pipe_pkg holds:
//   - opcode constants (AR/M/BR/SH) and funct3 constants (ADD..MUL, LW/SW, BEQ/BNE).
//   - the fwd_sel_t enum (REG/EXMEM/MEMWB) and the state_t enum.
//   - functions writes_rd(), reads_rs1(), reads_rs2(), store_src() and is_mul().
// Sub-module rv32i_fwd_unit: purely combinational forwarding mux-select logic; it is instantiated
// once and produces both fwd_a and fwd_b. The FSM, the counters and the hazard detection stay in
// rv32i_pipe_ctrl.
// TESTING
// 1. Reset: hold RN=1 for 2 cycles with all valids=1.
//    -> pc_en=0, if_id_flush=1, counters=0.
//    After release with idle stages -> pc_en=1 and if_id_en=1 in the first cycle.
// 2. Forward: mem_ir = add r6,r1,r2 (0x02208300), ex_ir = sub r7,r6,r2, wb_ir writes r6.
//    -> fwd_a=1 (EX/MEM has priority), fwd_b=0.
//    Same setup with mem_valid=0 -> fwd_a=2.
// 3. Load-use: ex_ir = lw r13,r1,2; id_ir = add r14,r13,r2.
//    -> exactly one cycle of pc_en=0 with id_ex_bubble=1, stall_cnt=1.
//    Same with id rs=r0 -> no stall.
// 4. MUL: ex_ir = mul r8,r1,r3 with MUL_LAT=4.
//    -> ex_hold=1 and pc_en=0 for 4 consecutive cycles, then RUN, stall_cnt=4.
//    Assert RN in the 2nd hold cycle -> RUN next cycle, counters 0.
// 5. Branch: beq taken in EX (0x00f00002) with a load-use hazard in the same cycle.
//    -> if_id_flush=1 for 3 cycles, flush_cnt=3, stall_cnt unchanged.
// 6. Saturation: CNT_W=4, 20 load-use stalls -> stall_cnt holds at 15.

Source files
------------

// File: rtl/rv32i_pipe_pkg.sv
// Shared decode constants, enums and instruction-classification helpers for
// the rv32i pipeline hazard/sequencing controller.
package rv32i_pipe_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [6:0] OP_AR = 7'd0;
  localparam logic [6:0] OP_M  = 7'd1;
  localparam logic [6:0] OP_BR = 7'd2;
  localparam logic [6:0] OP_SH = 7'd3;

  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SUB = 3'd1;
  localparam logic [2:0] F3_AND = 3'd2;
  localparam logic [2:0] F3_OR  = 3'd3;
  localparam logic [2:0] F3_XOR = 3'd4;
  localparam logic [2:0] F3_SLT = 3'd5;
  localparam logic [2:0] F3_MUL = 3'd6;
  localparam logic [2:0] F3_LW  = 3'd0;
  localparam logic [2:0] F3_SW  = 3'd1;
  localparam logic [2:0] F3_BEQ = 3'd0;
  localparam logic [2:0] F3_BNE = 3'd1;

  // funct7 value marking a register-register AR op (second source is rs2)
  localparam logic [6:0] F7_RR = 7'd1;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  function automatic logic is_lw(input logic [RV_XLEN-1:0] ir);
    return (ir[6:0] == OP_M) && (ir[14:12] == F3_LW);
  endfunction

  function automatic logic writes_rd(input logic [RV_XLEN-1:0] ir);
    return ((ir[6:0] == OP_AR) || (ir[6:0] == OP_SH) || is_lw(ir)) && (ir[11:7] != 5'd0);
  endfunction

  function automatic logic reads_rs1(input logic [RV_XLEN-1:0] ir);
    return (ir[6:0] == OP_AR) || (ir[6:0] == OP_SH) || (ir[6:0] == OP_M);
  endfunction

  function automatic logic reads_rs2(input logic [RV_XLEN-1:0] ir);
    return ((ir[6:0] == OP_AR) && (ir[31:25] == F7_RR)) || (ir[6:0] == OP_SH);
  endfunction

  // SW carries its store-data register in the rd field
  function automatic logic store_src(input logic [RV_XLEN-1:0] ir);
    return (ir[6:0] == OP_M) && (ir[14:12] == F3_SW);
  endfunction

  function automatic logic is_mul(input logic [RV_XLEN-1:0] ir);
    return (ir[6:0] == OP_AR) && (ir[31:25] == F7_RR) && (ir[14:12] == F3_MUL);
  endfunction

endpackage

// File: rtl/rv32i_pipe_ctrl_fwd.sv
// Combinational forwarding-select logic for both EX operands.
// EX/MEM wins over MEM/WB; a load sitting in EX/MEM is never a forward source.
module rv32i_fwd_unit
  import rv32i_pipe_pkg::*;
(
  input  logic [RV_XLEN-1:0] ex_ir,
  input  logic               ex_valid,
  input  logic [RV_XLEN-1:0] mem_ir,
  input  logic               mem_valid,
  input  logic [RV_XLEN-1:0] wb_ir,
  input  logic               wb_valid,
  output fwd_sel_t           fwd_a,
  output fwd_sel_t           fwd_b
);

  logic       mem_src;
  logic       wb_src;
  logic       use_a;
  logic       use_b;
  logic [4:0] reg_a;
  logic [4:0] reg_b;

  function automatic fwd_sel_t pick(input logic use_r, input logic [4:0] r,
                                    input logic m_ok, input logic [4:0] m_rd,
                                    input logic w_ok, input logic [4:0] w_rd);
    if (!use_r || (r == 5'd0)) return FWD_REG;
    if (m_ok && (m_rd == r))   return FWD_EXMEM;
    if (w_ok && (w_rd == r))   return FWD_MEMWB;
    return FWD_REG;
  endfunction

  always_comb begin
    mem_src = mem_valid && writes_rd(mem_ir) && !is_lw(mem_ir);
    wb_src  = wb_valid && writes_rd(wb_ir);
    use_a   = ex_valid && reads_rs1(ex_ir);
    reg_a   = ex_ir[19:15];
    use_b   = ex_valid && (reads_rs2(ex_ir) || store_src(ex_ir));
    reg_b   = reads_rs2(ex_ir) ? ex_ir[24:20] : ex_ir[11:7];
    fwd_a   = pick(use_a, reg_a, mem_src, mem_ir[11:7], wb_src, wb_ir[11:7]);
    fwd_b   = pick(use_b, reg_b, mem_src, mem_ir[11:7], wb_src, wb_ir[11:7]);
  end

endmodule

// File: rtl/rv32i_pipe_ctrl.sv
// Hazard/sequencing controller for the 5-stage rv32i pipeline: stalls, flushes,
// multi-cycle MUL hold, operand forwarding selects and saturating event counters.
module rv32i_pipe_ctrl
  import rv32i_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MUL_LAT   = 4,
  parameter int FLUSH_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             RN,
  input  logic [XLEN-1:0]  id_ir,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  ex_ir,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  mem_ir,
  input  logic             mem_valid,
  input  logic [XLEN-1:0]  wb_ir,
  input  logic             wb_valid,
  input  logic             br_taken,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output state_t           dbg_state
);

  localparam int MAXC = (MUL_LAT > FLUSH_CYC) ? MUL_LAT : FLUSH_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

  // Stage valid bits qualify every IR: an invalid slot is a bubble and is ignored.
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          pc_c, ifid_c, flush_c, bub_c, hold_c;
  logic          br_hit, mul_hit, lu_hit;
  logic [4:0]    ld_rd;
  fwd_sel_t      fwd_a_c, fwd_b_c;

  rv32i_fwd_unit u_fwd (
    .ex_ir     (ex_ir),
    .ex_valid  (ex_valid),
    .mem_ir    (mem_ir),
    .mem_valid (mem_valid),
    .wb_ir     (wb_ir),
    .wb_valid  (wb_valid),
    .fwd_a     (fwd_a_c),
    .fwd_b     (fwd_b_c)
  );

  always_comb begin
    ld_rd   = ex_ir[11:7];
    br_hit  = ex_valid && br_taken;
    mul_hit = ex_valid && is_mul(ex_ir) && (MUL_LAT > 1);
    lu_hit  = ex_valid && is_lw(ex_ir) && writes_rd(ex_ir) && id_valid &&
              ((reads_rs1(id_ir) && (id_ir[19:15] == ld_rd)) ||
               (reads_rs2(id_ir) && (id_ir[24:20] == ld_rd)) ||
               (store_src(id_ir) && (id_ir[11:7]  == ld_rd)));
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pc_c     = 1'b1;
    ifid_c   = 1'b1;
    flush_c  = 1'b0;
    bub_c    = 1'b0;
    hold_c   = 1'b0;
    case (state)
      ST_RUN: begin
        if (br_hit) begin
          flush_c = 1'b1;
          bub_c   = 1'b1;
          if (FLUSH_CYC > 1) begin
            cnt_nx   = CW'(FLUSH_CYC - 2);
            state_nx = ST_FLUSH;
          end
        end else if (mul_hit) begin
          hold_c   = 1'b1;
          pc_c     = 1'b0;
          ifid_c   = 1'b0;
          cnt_nx   = CW'(MUL_LAT - 2);
          state_nx = ST_MUL_WAIT;
        end else if (lu_hit) begin
          pc_c   = 1'b0;
          ifid_c = 1'b0;
          bub_c  = 1'b1;
        end
      end
      ST_MUL_WAIT: begin
        hold_c = 1'b1;
        pc_c   = 1'b0;
        ifid_c = 1'b0;
        if (cnt == '0) state_nx = ST_RUN;
        else           cnt_nx   = cnt - 1'b1;
      end
      ST_FLUSH: begin
        flush_c = 1'b1;
        bub_c   = 1'b1;
        if (cnt == '0) state_nx = ST_RUN;
        else           cnt_nx   = cnt - 1'b1;
      end
      default: state_nx = ST_RUN;
    endcase
  end

  // Reset overrides every control so the pipe fills with bubbles while RN is high
  always_comb begin
    pc_en        = RN ? 1'b0 : pc_c;
    if_id_en     = RN ? 1'b0 : ifid_c;
    if_id_flush  = RN ? 1'b1 : flush_c;
    id_ex_bubble = RN ? 1'b1 : bub_c;
    ex_hold      = RN ? 1'b0 : hold_c;
    fwd_a        = RN ? 2'd0 : fwd_a_c;
    fwd_b        = RN ? 2'd0 : fwd_b_c;
    dbg_state    = state;
  end

  always_ff @(posedge clk) begin
    if (RN) begin
      state     <= ST_RUN;
      cnt       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (!pc_c && (stall_cnt != '1))   stall_cnt <= stall_cnt + 1'b1;
      if (flush_c && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Directed bench for rv32i_pipe_ctrl: the driver pushes a hand-computed expected
// output vector per cycle, a negedge monitor pops and compares it.
module tb_rv32i_pipe_ctrl;
  import rv32i_pipe_pkg::*;

  localparam int W = 45;
  localparam logic [4:0] C_RUN = 5'b11000;  // {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_hold}
  localparam logic [4:0] C_RST = 5'b00110;
  localparam logic [4:0] C_LU  = 5'b00010;
  localparam logic [4:0] C_MUL = 5'b00001;
  localparam logic [4:0] C_FL  = 5'b11110;

  // Hand-encoded instructions: {funct7, rs2, rs1, funct3, rd, opcode}
  localparam logic [31:0] ADD_R6   = 32'h0220_8300;                          // add r6,r1,r2
  localparam logic [31:0] SUB_R7   = {7'd1, 5'd2, 5'd6, 3'd1, 5'd7, 7'd0};   // sub r7,r6,r2
  localparam logic [31:0] WB_R6    = {7'd1, 5'd3, 5'd4, 3'd0, 5'd6, 7'd0};   // add r6,r4,r3
  localparam logic [31:0] LW_R6    = {7'd0, 5'd0, 5'd1, 3'd0, 5'd6, 7'd1};   // lw r6,r1,0
  localparam logic [31:0] ADD_R9   = {7'd1, 5'd6, 5'd0, 3'd0, 5'd9, 7'd0};   // add r9,r0,r6
  localparam logic [31:0] LW_R13   = {7'd0, 5'd2, 5'd1, 3'd0, 5'd13, 7'd1};  // lw r13,r1,2
  localparam logic [31:0] ADD_R14  = {7'd1, 5'd2, 5'd13, 3'd0, 5'd14, 7'd0}; // add r14,r13,r2
  localparam logic [31:0] ADD_R0S  = {7'd1, 5'd0, 5'd0, 3'd0, 5'd14, 7'd0}; // add r14,r0,r0
  localparam logic [31:0] SW_R13   = {7'd0, 5'd0, 5'd1, 3'd1, 5'd13, 7'd1};  // sw r13 -> [r1]
  localparam logic [31:0] MUL_R8   = {7'd1, 5'd3, 5'd1, 3'd6, 5'd8, 7'd0};   // mul r8,r1,r3
  localparam logic [31:0] BEQ      = 32'h00f0_0002;

  logic        clk;
  logic        RN;
  logic [31:0] id_ir, ex_ir, mem_ir, wb_ir;
  logic        id_valid, ex_valid, mem_valid, wb_valid, br_taken;
  logic        pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_hold;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;
  state_t      dbg_state;
  logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_bubble, s_ex_hold;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [3:0]  s_stall_cnt, s_flush_cnt;
  state_t      s_dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        tag_q[$];
  int           n_tests;
  int           n_fail;

  rv32i_pipe_ctrl dut (
    .clk(clk), .RN(RN),
    .id_ir(id_ir), .id_valid(id_valid), .ex_ir(ex_ir), .ex_valid(ex_valid),
    .mem_ir(mem_ir), .mem_valid(mem_valid), .wb_ir(wb_ir), .wb_valid(wb_valid),
    .br_taken(br_taken),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dbg_state(dbg_state)
  );

  rv32i_pipe_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .RN(RN),
    .id_ir(id_ir), .id_valid(id_valid), .ex_ir(ex_ir), .ex_valid(ex_valid),
    .mem_ir(mem_ir), .mem_valid(mem_valid), .wb_ir(wb_ir), .wb_valid(wb_valid),
    .br_taken(br_taken),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush),
    .id_ex_bubble(s_id_ex_bubble), .ex_hold(s_ex_hold), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .dbg_state(s_dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic set_idle();
    id_ir = '0; ex_ir = '0; mem_ir = '0; wb_ir = '0;
    id_valid = 1'b0; ex_valid = 1'b0; mem_valid = 1'b0; wb_valid = 1'b0;
    br_taken = 1'b0;
  endtask

  // Counter arguments of -1 are not checked
  task automatic expect_cycle(input string tag, input logic [4:0] c,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input int sc, input int fc, input int ss);
    logic [W-1:0] e;
    logic [W-1:0] m;
    e = {c, fa, fb, sc[15:0], fc[15:0], ss[3:0]};
    m = {9'h1ff, (sc < 0) ? 16'h0 : 16'hffff, (fc < 0) ? 16'h0 : 16'hffff,
         (ss < 0) ? 4'h0 : 4'hf};
    exp_q.push_back(e);
    mask_q.push_back(m);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] act, e, m;
    string        tag;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      m   = mask_q.pop_front();
      tag = tag_q.pop_front();
      act = {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_hold, fwd_a, fwd_b,
             stall_cnt, flush_cnt, s_stall_cnt};
      n_tests++;
      if (((act ^ e) & m) !== '0) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (care mask %h)", tag, act, e, m);
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset with every slot valid and hazards present on the inputs
    RN = 1'b1;
    set_idle();
    id_valid = 1'b1; ex_valid = 1'b1; mem_valid = 1'b1; wb_valid = 1'b1;
    id_ir = ADD_R14; ex_ir = LW_R13; mem_ir = ADD_R6; wb_ir = WB_R6; br_taken = 1'b1;
    @(posedge clk);
    #1;
    expect_cycle("reset_1", C_RST, 2'd0, 2'd0, 0, 0, 0);
    expect_cycle("reset_2", C_RST, 2'd0, 2'd0, 0, 0, 0);
    RN = 1'b0;
    set_idle();
    expect_cycle("post_reset_run", C_RUN, 2'd0, 2'd0, 0, 0, 0);

    // Forwarding
    ex_valid = 1'b1; ex_ir = SUB_R7;
    mem_valid = 1'b1; mem_ir = ADD_R6;
    wb_valid = 1'b1; wb_ir = WB_R6;
    expect_cycle("fwd_exmem_prio", C_RUN, 2'd1, 2'd0, 0, 0, -1);
    mem_valid = 1'b0;
    expect_cycle("fwd_memwb", C_RUN, 2'd2, 2'd0, 0, 0, -1);
    mem_valid = 1'b1; mem_ir = LW_R6;
    expect_cycle("fwd_no_lw_exmem", C_RUN, 2'd2, 2'd0, 0, 0, -1);
    wb_ir = LW_R6;
    mem_valid = 1'b0;
    expect_cycle("fwd_lw_from_wb", C_RUN, 2'd2, 2'd0, 0, 0, -1);
    wb_valid = 1'b0;
    expect_cycle("fwd_none_invalid", C_RUN, 2'd0, 2'd0, 0, 0, -1);
    ex_ir = ADD_R9; mem_valid = 1'b1; mem_ir = ADD_R6;
    expect_cycle("fwd_b_r0_a", C_RUN, 2'd0, 2'd1, 0, 0, -1);

    // Load-use
    set_idle();
    ex_valid = 1'b1; ex_ir = LW_R13; id_valid = 1'b1; id_ir = ADD_R14;
    expect_cycle("lu_stall", C_LU, 2'd0, 2'd0, 0, 0, 0);
    set_idle();
    ex_valid = 1'b1; ex_ir = ADD_R14; mem_valid = 1'b1; mem_ir = LW_R13;
    expect_cycle("lu_clear", C_RUN, 2'd0, 2'd0, 1, 0, 1);
    set_idle();
    ex_valid = 1'b1; ex_ir = LW_R13; id_valid = 1'b1; id_ir = ADD_R0S;
    expect_cycle("lu_rs_r0", C_RUN, 2'd0, 2'd0, 1, 0, -1);
    id_ir = SW_R13;
    expect_cycle("lu_store_data", C_LU, 2'd0, 2'd0, 1, 0, -1);
    id_ir = ADD_R14; id_valid = 1'b0;
    expect_cycle("lu_id_invalid", C_RUN, 2'd0, 2'd0, 2, 0, 2);

    // MUL hold, with a branch pulse inside the hold that must be ignored
    set_idle();
    ex_valid = 1'b1; ex_ir = MUL_R8;
    expect_cycle("mul_hold_1", C_MUL, 2'd0, 2'd0, 2, 0, -1);
    expect_cycle("mul_hold_2", C_MUL, 2'd0, 2'd0, 3, 0, -1);
    br_taken = 1'b1;
    expect_cycle("mul_hold_3_br", C_MUL, 2'd0, 2'd0, 4, 0, -1);
    br_taken = 1'b0;
    expect_cycle("mul_hold_4", C_MUL, 2'd0, 2'd0, 5, 0, -1);
    set_idle();
    expect_cycle("mul_done", C_RUN, 2'd0, 2'd0, 6, 0, 6);
    ex_valid = 1'b1; ex_ir = MUL_R8;
    expect_cycle("mul_rst_hold_1", C_MUL, 2'd0, 2'd0, 6, 0, -1);
    RN = 1'b1;
    expect_cycle("mul_rst_asserted", C_RST, 2'd0, 2'd0, 7, 0, -1);
    RN = 1'b0;
    set_idle();
    expect_cycle("mul_rst_run", C_RUN, 2'd0, 2'd0, 0, 0, 0);

    // Branch beats a simultaneous load-use hazard
    ex_valid = 1'b1; ex_ir = LW_R13; id_valid = 1'b1; id_ir = ADD_R14; br_taken = 1'b1;
    expect_cycle("br_lu_flush_1", C_FL, 2'd0, 2'd0, 0, 0, 0);
    br_taken = 1'b0;
    expect_cycle("br_lu_flush_2", C_FL, 2'd0, 2'd0, 0, 1, -1);
    expect_cycle("br_lu_flush_3", C_FL, 2'd0, 2'd0, 0, 2, -1);
    set_idle();
    expect_cycle("br_lu_done", C_RUN, 2'd0, 2'd0, 0, 3, 0);
    ex_valid = 1'b1; ex_ir = BEQ; br_taken = 1'b1;
    expect_cycle("beq_flush_1", C_FL, 2'd0, 2'd0, 0, 3, -1);
    set_idle();
    expect_cycle("beq_flush_2", C_FL, 2'd0, 2'd0, 0, 4, -1);
    expect_cycle("beq_flush_3", C_FL, 2'd0, 2'd0, 0, 5, -1);
    ex_valid = 1'b1; ex_ir = BEQ;
    expect_cycle("beq_not_taken", C_RUN, 2'd0, 2'd0, 0, 6, -1);
    ex_valid = 1'b0; br_taken = 1'b1;
    expect_cycle("br_ex_invalid", C_RUN, 2'd0, 2'd0, 0, 6, -1);

    // Saturation: the CNT_W=4 instance stops at 15 while the 16-bit one keeps counting
    set_idle();
    ex_valid = 1'b1; ex_ir = LW_R13; id_valid = 1'b1; id_ir = ADD_R14;
    for (int i = 0; i < 20; i++) begin
      expect_cycle($sformatf("sat_stall_%0d", i), C_LU, 2'd0, 2'd0, i, 6,
                   (i > 15) ? 15 : i);
    end
    set_idle();
    expect_cycle("sat_final", C_RUN, 2'd0, 2'd0, 20, 6, 15);

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
